// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, EX-stage operand forwarding
// and load-use hazard detection feeding the pipeline controller.
module id_ex_stage #(
    parameter int W  = 32,
    parameter int RA = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [W-1:0]  id_rs_data,
    input  logic [W-1:0]  id_rt_data,
    input  logic [W-1:0]  id_imm,
    input  logic [RA-1:0] id_rs,
    input  logic [RA-1:0] id_rt,
    input  logic [RA-1:0] id_rd,
    input  logic [5:0]    id_funct,
    input  logic [1:0]    id_alu_op,
    input  logic          id_alu_src,
    input  logic          id_reg_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          exmem_reg_write,
    input  logic [RA-1:0] exmem_rd,
    input  logic [W-1:0]  exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RA-1:0] memwb_rd,
    input  logic [W-1:0]  memwb_result,
    output logic [W-1:0]  ex_A,
    output logic [W-1:0]  ex_B,
    output logic [2:0]    ex_ALUctrl,
    output logic [W-1:0]  ex_store_data,
    output logic [RA-1:0] ex_wr_reg,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic          ex_bad_funct,
    output logic          load_use_hz
);

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [W-1:0]  rs_data_q, rt_data_q, imm_q;
    logic [RA-1:0] rs_q, rt_q;
    logic          alu_src_q;
    logic [2:0]    alu_ctrl_d;
    logic          bad_funct_d;
    logic          bubble;
    logic [W-1:0]  fwd_rs, fwd_rt;

    // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_ctrl_d  = ALU_ADD;
        bad_funct_d = 1'b0;
        case (id_alu_op)
            2'b00: alu_ctrl_d = ALU_ADD;
            2'b01: alu_ctrl_d = ALU_SUB;
            2'b11: alu_ctrl_d = ALU_OR;
            default: begin
                case (id_funct)
                    6'b100000: alu_ctrl_d = ALU_ADD;
                    6'b100010: alu_ctrl_d = ALU_SUB;
                    6'b100100: alu_ctrl_d = ALU_AND;
                    6'b100101: alu_ctrl_d = ALU_OR;
                    6'b101010: alu_ctrl_d = ALU_SLT;
                    default:   bad_funct_d = 1'b1;
                endcase
            end
        endcase
    end

    assign load_use_hz = ex_valid && ex_mem_read && (ex_wr_reg != '0) &&
                         ((ex_wr_reg == id_rs) || (ex_wr_reg == id_rt));

    // Reset and bubble share one clear path; stall only blocks the load.
    assign bubble = flush || (!stall && (load_use_hz || !id_valid));

    // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            alu_src_q     <= 1'b0;
            ex_wr_reg     <= '0;
            ex_ALUctrl    <= ALU_ADD;
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_bad_funct  <= 1'b0;
        end else if (!stall) begin
            rs_data_q     <= id_rs_data;
            rt_data_q     <= id_rt_data;
            imm_q         <= id_imm;
            rs_q          <= id_rs;
            rt_q          <= id_rt;
            alu_src_q     <= id_alu_src;
            ex_wr_reg     <= id_reg_dst ? id_rd : id_rt;
            ex_ALUctrl    <= alu_ctrl_d;
            ex_valid      <= 1'b1;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_bad_funct  <= bad_funct_d;
        end
    end

    // EX/MEM beats MEM/WB; register 0 is hardwired and never forwarded.
    function automatic logic [W-1:0] forward(
        input logic [RA-1:0] src,
        input logic [W-1:0]  reg_data,
        input logic          em_we,
        input logic [RA-1:0] em_rd,
        input logic [W-1:0]  em_res,
        input logic          mw_we,
        input logic [RA-1:0] mw_rd,
        input logic [W-1:0]  mw_res
    );
        if (em_we && (em_rd != '0) && (em_rd == src))
            return em_res;
        else if (mw_we && (mw_rd != '0) && (mw_rd == src))
            return mw_res;
        else
            return reg_data;
    endfunction

    assign fwd_rs = forward(rs_q, rs_data_q, exmem_reg_write, exmem_rd, exmem_result,
                            memwb_reg_write, memwb_rd, memwb_result);
    assign fwd_rt = forward(rt_q, rt_data_q, exmem_reg_write, exmem_rd, exmem_result,
                            memwb_reg_write, memwb_rd, memwb_result);

    assign ex_A          = fwd_rs;
    assign ex_store_data = fwd_rt;
    assign ex_B          = alu_src_q ? imm_q : fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, forwarding priority, load-use bubbles,
// stall/flush precedence and reset behaviour.
module tb_id_ex_stage;

    localparam int W  = 32;
    localparam int RA = 5;

    logic          clk = 1'b0;
    logic          rst, stall, flush, id_valid;
    logic [W-1:0]  id_rs_data, id_rt_data, id_imm;
    logic [RA-1:0] id_rs, id_rt, id_rd;
    logic [5:0]    id_funct;
    logic [1:0]    id_alu_op;
    logic          id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic          exmem_reg_write, memwb_reg_write;
    logic [RA-1:0] exmem_rd, memwb_rd;
    logic [W-1:0]  exmem_result, memwb_result;
    logic [W-1:0]  ex_A, ex_B, ex_store_data;
    logic [2:0]    ex_ALUctrl;
    logic [RA-1:0] ex_wr_reg;
    logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic          ex_bad_funct, load_use_hz;

    int checks = 0;
    int errors = 0;

    logic [5:0] functs [6];
    logic [2:0] codes  [6];

    id_ex_stage #(.W(W), .RA(RA)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_A(ex_A), .ex_B(ex_B), .ex_ALUctrl(ex_ALUctrl), .ex_store_data(ex_store_data),
        .ex_wr_reg(ex_wr_reg), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_bad_funct(ex_bad_funct),
        .load_use_hz(load_use_hz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 1'b0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_funct = '0; id_alu_op = '0;
        id_alu_src = 1'b0; id_reg_dst = 1'b0; id_reg_write = 1'b0;
        id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_valid"}, 32'(ex_valid), 0);
        check({tag, "_regwr"}, 32'(ex_reg_write), 0);
        check({tag, "_memrd"}, 32'(ex_mem_read), 0);
        check({tag, "_memwr"}, 32'(ex_mem_write), 0);
        check({tag, "_m2r"}, 32'(ex_mem_to_reg), 0);
        check({tag, "_bad"}, 32'(ex_bad_funct), 0);
    endtask

    initial begin
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};
        codes  = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
        stall = 1'b0; flush = 1'b0;
        clear_inputs();

        // Reset with random activity on every input
        rst = 1'b1;
        id_valid = 1'b1; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
        id_funct = 6'($urandom); id_alu_op = 2'($urandom); id_alu_src = 1'($urandom);
        id_reg_write = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b1; id_mem_to_reg = 1'b1;
        exmem_reg_write = 1'b1; exmem_rd = 5'($urandom); exmem_result = $urandom;
        memwb_reg_write = 1'b1; memwb_rd = 5'($urandom); memwb_result = $urandom;
        step(); step();
        check_bubble("rst");
        check("rst_A", ex_A, 0);
        check("rst_B", ex_B, 0);
        check("rst_store", ex_store_data, 0);
        check("rst_aluctrl", 32'(ex_ALUctrl), 3'b010);
        check("rst_wr_reg", 32'(ex_wr_reg), 0);
        check("rst_hz", 32'(load_use_hz), 0);
        rst = 1'b0;
        clear_inputs();

        // R-type funct decode
        id_valid = 1'b1; id_alu_op = 2'b10; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
        id_reg_dst = 1'b1; id_reg_write = 1'b1;
        for (int i = 0; i < 6; i++) begin
            id_funct = functs[i];
            step();
            check($sformatf("rtype_ctrl_%h", functs[i]), 32'(ex_ALUctrl), 32'(codes[i]));
            check($sformatf("rtype_bad_%h", functs[i]), 32'(ex_bad_funct), (i == 5) ? 1 : 0);
        end
        check("rtype_valid", 32'(ex_valid), 1);
        check("rtype_wr_reg", 32'(ex_wr_reg), 3);

        // Non-R-type alu_op ignores funct, even an unsupported one
        id_funct = 6'h3F;
        id_alu_op = 2'b00; step(); check("op00_ctrl", 32'(ex_ALUctrl), 3'b010);
        check("op00_bad", 32'(ex_bad_funct), 0);
        id_alu_op = 2'b01; step(); check("op01_ctrl", 32'(ex_ALUctrl), 3'b110);
        id_alu_op = 2'b11; step(); check("op11_ctrl", 32'(ex_ALUctrl), 3'b001);
        check("op11_bad", 32'(ex_bad_funct), 0);

        // Forwarding priority on registered rs=5, rt=6
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd5; id_rt = 5'd6; id_rd = 5'd7; id_reg_dst = 1'b1;
        id_rs_data = 32'h1111_1111; id_rt_data = 32'h2222_2222; id_reg_write = 1'b1;
        step();
        id_valid = 1'b0;
        exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAAAA_0000;
        memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'h0000_5555;
        #1;
        check("fwd_exmem_wins", ex_A, 32'hAAAA_0000);
        check("fwd_rt_untouched", ex_B, 32'h2222_2222);
        exmem_reg_write = 1'b0; #1;
        check("fwd_memwb", ex_A, 32'h0000_5555);
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0; #1;
        check("fwd_r0_never", ex_A, 32'h1111_1111);
        memwb_rd = 5'd6; #1;
        check("fwd_rt_B", ex_B, 32'h0000_5555);
        check("fwd_rt_store", ex_store_data, 32'h0000_5555);

        // Invalid ID slot loads a bubble
        clear_inputs();
        step();
        check_bubble("idle");
        check("idle_A", ex_A, 0);
        check("idle_wr_reg", 32'(ex_wr_reg), 0);

        // Immediate path
        id_valid = 1'b1; id_alu_src = 1'b1; id_imm = 32'hFFFF_FFFC; id_alu_op = 2'b00;
        id_rs = 5'd4; id_rt = 5'd9; id_rs_data = 32'h10; id_rt_data = 32'h1234_5678;
        step();
        memwb_reg_write = 1'b1; memwb_rd = 5'd9; memwb_result = 32'hCAFE_BABE;
        #1;
        check("imm_B", ex_B, 32'hFFFF_FFFC);
        check("imm_ctrl", 32'(ex_ALUctrl), 3'b010);
        check("imm_store", ex_store_data, 32'hCAFE_BABE);
        check("imm_A", ex_A, 32'h10);
        check("imm_wr_reg", 32'(ex_wr_reg), 9);

        // Load-use: lw r8 then add using r8 as rs
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd2; id_rt = 5'd8; id_alu_src = 1'b1; id_imm = 32'd4;
        id_reg_write = 1'b1; id_mem_read = 1'b1; id_mem_to_reg = 1'b1;
        step();
        check("lw_wr_reg", 32'(ex_wr_reg), 8);
        check("lw_m2r", 32'(ex_mem_to_reg), 1);
        id_rs = 5'd8; id_rt = 5'd3; id_rd = 5'd10; id_reg_dst = 1'b1; id_alu_src = 1'b0;
        id_mem_read = 1'b0; id_mem_to_reg = 1'b0; id_alu_op = 2'b10; id_funct = 6'h20;
        id_rs_data = 32'h0000_DEAD; id_rt_data = 32'h3; id_imm = '0;
        #1;
        check("lu_hz", 32'(load_use_hz), 1);
        step();
        check_bubble("lu_bubble");
        check("lu_hz_drop", 32'(load_use_hz), 0);
        step();
        check("lu_add_valid", 32'(ex_valid), 1);
        check("lu_add_wr_reg", 32'(ex_wr_reg), 10);
        memwb_reg_write = 1'b1; memwb_rd = 5'd8; memwb_result = 32'h00BE_EF00;
        #1;
        check("lu_add_fwd_A", ex_A, 32'h00BE_EF00);
        check("lu_add_B", ex_B, 32'h3);

        // Stall during a pending hazard (rt match), then exactly one bubble
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd8; id_reg_write = 1'b1;
        id_mem_read = 1'b1; id_alu_src = 1'b1;
        step();
        id_mem_read = 1'b0; id_alu_src = 1'b0; id_rd = 5'd12; id_reg_dst = 1'b1;
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_hz_held", 32'(load_use_hz), 1);
            check("stall_load_kept", 32'(ex_mem_read), 1);
            check("stall_load_wr", 32'(ex_wr_reg), 8);
        end
        stall = 1'b0;
        step();
        check_bubble("stall_hz_bubble");
        step();
        check("stall_hz_load", 32'(ex_valid), 1);
        check("stall_hz_wr", 32'(ex_wr_reg), 12);

        // Stall holds a valid add; stall+flush then bubbles
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd11; id_reg_dst = 1'b1;
        id_rs_data = 32'h100; id_rt_data = 32'h200; id_reg_write = 1'b1;
        step();
        stall = 1'b1; id_rd = 5'd13; id_rs_data = 32'h999; id_rt_data = 32'h888;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_A", ex_A, 32'h100);
            check("hold_B", ex_B, 32'h200);
            check("hold_wr", 32'(ex_wr_reg), 11);
            check("hold_valid", 32'(ex_valid), 1);
        end
        flush = 1'b1;
        step();
        check_bubble("flush");
        check("flush_A", ex_A, 0);
        check("flush_B", ex_B, 0);
        check("flush_wr", 32'(ex_wr_reg), 0);
        stall = 1'b0; flush = 1'b0;

        // Reset mid-operation drops the in-flight instruction
        step();
        check("pre_rst_valid", 32'(ex_valid), 1);
        id_alu_op = 2'b01; id_rs_data = 32'h7777;
        rst = 1'b1;
        step();
        check_bubble("midrst");
        check("midrst_ctrl", 32'(ex_ALUctrl), 3'b010);
        check("midrst_A", ex_A, 0);
        check("midrst_wr", 32'(ex_wr_reg), 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the execute-stage ALU. It registers decoded operands and control, produces the 3-bit ALU control code, and resolves EX/MEM and MEM/WB data forwarding into the final A/B operands. It also detects load-use hazards and inserts bubbles, and accepts stall/flush from the pipeline controller.

## Interface
- Parameters:
- `W`, 32, datapath width
- `RA`, 5, register-address width
- Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `stall`  in  1  hold all ID/EX registers
- `flush`  in  1  load a bubble (branch/jump squash)
- `id_valid`  in  1  ID slot holds a real instruction
- `id_rs_data`, `id_rt_data`  in  W  register-file read data
- `id_imm`  in  W  sign/zero-extended immediate
- `id_rs`, `id_rt`, `id_rd`  in  RA  register specifiers
- `id_funct`  in  6  R-type funct field
- `id_alu_op`  in  2  00 add, 01 sub, 10 decode funct, 11 or
- `id_alu_src`  in  1  1: B = immediate, 0: B = rt operand
- `id_reg_dst`  in  1  1: dest = rd, 0: dest = rt
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`  in  1  control bits carried forward
- `exmem_reg_write`  in  1, `exmem_rd`  in  RA, `exmem_result`  in  W  EX/MEM forwarding source
- `memwb_reg_write`  in  1, `memwb_rd`  in  RA, `memwb_result`  in  W  MEM/WB forwarding source
- `ex_A`, `ex_B`  out  W  ALU operands (forwarded)
- `ex_ALUctrl`  out  3  ALU control code
- `ex_store_data`  out  W  forwarded rt value for stores
- `ex_wr_reg`  out  RA  destination register
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`  out  1  registered control
- `ex_bad_funct`  out  1  registered: unsupported funct under alu_op 10
- `load_use_hz`  out  1  combinational hazard flag to the pipeline controller (stall IF/ID, PC)

## Operation
- The ALU control code is decoded at ID and registered. alu_op 00→010, 01→110, 11→001. With alu_op 10, funct 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Any other funct→010 and sets `ex_bad_funct`=1.
- `ex_wr_reg` is `id_rd` if `id_reg_dst`=1, else `id_rt`. It is registered.
- Registered fields: rs_data, rt_data, imm, rs, rt, wr_reg, ALUctrl, alu_src, and all control bits.
- Forwarding is combinational in EX and uses the registered rs/rt:
  - Operand X (rs or rt) takes `exmem_result` if `exmem_reg_write` && `exmem_rd`!=0 && `exmem_rd`==X.
  - Otherwise it takes `memwb_result` under the same conditions using the memwb_* inputs.
  - Otherwise it takes the registered data.
  - EX/MEM has priority over MEM/WB.
- `ex_A` = forwarded rs. `ex_store_data` = forwarded rt. `ex_B` = registered imm if alu_src=1, else forwarded rt.
- `load_use_hz` = `ex_valid` && `ex_mem_read` && `ex_wr_reg`!=0 && (`ex_wr_reg`==`id_rs` || `ex_wr_reg`==`id_rt`).
- A bubble means: `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, and `ex_bad_funct` are all 0. Data fields are cleared to 0; rs/rt/wr_reg are cleared to 0.
- Per-edge priority:
  1. `rst`: all registers 0, ALUctrl 010.
  2. `flush`: bubble.
  3. `stall`: hold.
  4. `load_use_hz` or !`id_valid`: bubble.
  5. Otherwise: load ID inputs.

## Timing
- Latency is 1 cycle from ID inputs to registered EX outputs. Forwarded outputs settle combinationally within the same cycle as the forwarding inputs.
- Reset values:
  - `ex_A`, `ex_B`, `ex_store_data`: 0, because rs/rt are reset to 0 and therefore never forwarded.
  - `ex_ALUctrl`: 010.
  - `ex_wr_reg`: 0.
  - All control outputs and `ex_bad_funct`: 0.
  - `load_use_hz`: 0.
- flush and stall in the same cycle: flush wins.
- A stall during a pending hazard holds the load in EX. `load_use_hz` stays asserted until the stall releases, then exactly one bubble is inserted.
- A load-use hazard produces exactly one bubble. On the next cycle the load has moved out of EX, `load_use_hz` drops, and the held ID instruction loads. Its operand is then supplied by the MEM/WB forward.
- Reset mid-operation discards the in-flight instruction on that edge, with no partial update.
- Register 0 is never forwarded, even with write-enable set.

## Test plan
- Reset: assert `rst` with random inputs → all outputs 0, `ex_ALUctrl`=010, `load_use_hz`=0.
- R-type decode: one cycle each with alu_op=10 and funct 20/22/24/25/2A/3F (hex) → `ex_ALUctrl` is 010/110/000/001/111/010. `ex_bad_funct`=1 only for 3F.
- Forward priority: registered rs=5, both `exmem_rd` and `memwb_rd` =5 with writes on, `exmem_result`=0xAAAA0000, `memwb_result`=0x5555 → `ex_A`=0xAAAA0000. Drop `exmem_reg_write` → `ex_A`=0x5555. Set rd=0 on both → `ex_A` = registered data.
- Load-use: lw to r8 in EX, then ID with rs=8 → `load_use_hz`=1 and the next EX is a bubble (`ex_valid`=0). The following cycle the add loads and forwards `memwb_result`.
- Stall/flush interaction: valid add in EX, `stall`=1 for 3 cycles → outputs unchanged. Then `stall`=`flush`=1 → bubble.
- Immediate path: alu_src=1, imm=0xFFFFFFFC, alu_op=00 → `ex_B`=0xFFFFFFFC, `ex_ALUctrl`=010, `ex_store_data` = forwarded rt.
